// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment constants, scan FSM states and pattern decoder
package seg7_pkg;

  // Active-low segment patterns, bit0=a ... bit6=g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} scan_state_e;

  // Returns {legal, nibble}; illegal patterns (including blank) return 5'h00
  function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      SEG_0:   r = 5'h10;
      SEG_1:   r = 5'h11;
      SEG_2:   r = 5'h12;
      SEG_3:   r = 5'h13;
      SEG_4:   r = 5'h14;
      SEG_5:   r = 5'h15;
      SEG_6:   r = 5'h16;
      SEG_7:   r = 5'h17;
      SEG_8:   r = 5'h18;
      SEG_9:   r = 5'h19;
      SEG_A:   r = 5'h1A;
      SEG_B:   r = 5'h1B;
      SEG_C:   r = 5'h1C;
      SEG_D:   r = 5'h1D;
      SEG_E:   r = 5'h1E;
      SEG_F:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_sync_filter.sv
// rtl/seg_sync_filter.sv - 2-FF synchroniser and settle filter emitting a capture strobe
module seg_sync_filter
  import seg7_pkg::*;
#(
  parameter int W             = 15,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] sample_o,
  output logic         cap_o
);

  localparam logic [8:0] STABLE_N = 9'(STABLE_CYCLES);

  logic [W-1:0] sync1_q, sync2_q, prev_q;
  scan_state_e  state_q;
  logic [7:0]   cnt_q;
  logic         changed;
  logic         leave_idle;
  logic [8:0]   next_cnt;

  assign changed    = (sync2_q != prev_q);
  assign leave_idle = (sync2_q != {W{1'b1}});
  assign next_cnt   = changed ? 9'd1 : ({1'b0, cnt_q} + 9'd1);
  assign sample_o   = sync2_q;

  // Strobe is combinational so the top's registers update on the edge the count completes
  always_comb begin
    cap_o = 1'b0;
    case (state_q)
      IDLE:    cap_o = leave_idle && (STABLE_N == 9'd1);
      SETTLE:  cap_o = (next_cnt == STABLE_N);
      HOLD:    cap_o = changed && (STABLE_N == 9'd1);
      default: cap_o = 1'b0;
    endcase
  end

  // Synchroniser resets to all-ones so the bus looks blank until real data arrives
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= {W{1'b1}};
      sync2_q <= {W{1'b1}};
      prev_q  <= {W{1'b1}};
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Settle FSM: count identical samples, capture once per stable run
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (leave_idle) begin
            cnt_q   <= 8'd1;
            state_q <= cap_o ? HOLD : SETTLE;
          end
        end
        SETTLE: begin
          cnt_q <= next_cnt[7:0];
          if (cap_o) state_q <= HOLD;
        end
        HOLD: begin
          if (changed) begin
            cnt_q   <= 8'd1;
            state_q <= cap_o ? HOLD : SETTLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - 7-segment scan bus monitor recovering per-digit hex values (option: SEG_CAPTURE_DP_EN)
module seg_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [6:0]  SEG_IN,
  input  logic [7:0]  AN_IN,
`ifdef SEG_CAPTURE_DP_EN
  input  logic        DP_IN,
  output logic [7:0]  DP_OUT,
`endif
  output logic [31:0] DIGITS,
  output logic [7:0]  VALID,
  output logic [7:0]  BAD,
  output logic        AN_ERR,
  output logic        FRAME
);

`ifdef SEG_CAPTURE_DP_EN
  localparam int W = 16;
  logic [W-1:0] raw;
  assign raw = {DP_IN, AN_IN, SEG_IN};
`else
  localparam int W = 15;
  logic [W-1:0] raw;
  assign raw = {AN_IN, SEG_IN};
`endif

  logic [W-1:0] sample;
  logic         cap;

  seg_sync_filter #(
    .W            (W),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .raw_i   (raw),
    .sample_o(sample),
    .cap_o   (cap)
  );

  logic [31:0]           digits_q, digits_d;
  logic [7:0]            valid_q, valid_d;
  logic [7:0]            bad_q, bad_d;
  logic                  an_err_q, an_err_d;
  logic                  frame_q, frame_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d, seen_next;
  logic [6:0]            seg;
  logic [7:0]            an;
  logic [3:0]            zeros;
  logic [2:0]            idx;
  logic [4:0]            dec;
`ifdef SEG_CAPTURE_DP_EN
  logic [7:0]            dp_q, dp_d;
`endif

  assign seg = sample[6:0];
  assign an  = sample[14:7];

  // Locate the lit anode and count how many anodes are driven low
  always_comb begin
    zeros = 4'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) begin
        zeros = zeros + 4'd1;
        idx   = 3'(i);
      end
    end
  end

  // Apply one capture to the per-digit state and track frame completion
  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    bad_d     = bad_q;
    an_err_d  = an_err_q;
    seen_d    = seen_q;
    seen_next = seen_q;
    frame_d   = 1'b0;
    dec       = seg7_decode(seg);
`ifdef SEG_CAPTURE_DP_EN
    dp_d      = dp_q;
`endif
    if (cap) begin
      if (zeros > 4'd1) begin
        an_err_d = 1'b1;
      end else if (zeros == 4'd1) begin
        if (dec[4]) begin
          digits_d[{idx, 2'b00} +: 4] = dec[3:0];
          valid_d[idx] = 1'b1;
          bad_d[idx]   = 1'b0;
        end else begin
          valid_d[idx] = 1'b0;
          bad_d[idx]   = (seg != SEG_BLANK);
        end
`ifdef SEG_CAPTURE_DP_EN
        dp_d[idx] = ~sample[15];
`endif
        seen_next[idx] = 1'b1;
        if (&seen_next) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end else begin
          seen_d  = seen_next;
        end
      end
    end
  end

  // Output and bookkeeping registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      digits_q <= 32'd0;
      valid_q  <= 8'd0;
      bad_q    <= 8'd0;
      an_err_q <= 1'b0;
      frame_q  <= 1'b0;
      seen_q   <= '0;
`ifdef SEG_CAPTURE_DP_EN
      dp_q     <= 8'd0;
`endif
    end else begin
      digits_q <= digits_d;
      valid_q  <= valid_d;
      bad_q    <= bad_d;
      an_err_q <= an_err_d;
      frame_q  <= frame_d;
      seen_q   <= seen_d;
`ifdef SEG_CAPTURE_DP_EN
      dp_q     <= dp_d;
`endif
    end
  end

  assign DIGITS = digits_q;
  assign VALID  = valid_q;
  assign BAD    = bad_q;
  assign AN_ERR = an_err_q;
  assign FRAME  = frame_q;
`ifdef SEG_CAPTURE_DP_EN
  assign DP_OUT = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - randomized self-checking bench for seg_scan_capture
module tb_seg_scan_capture;

  localparam int S = 4;
  localparam logic [15:0] BLANK_IN = 16'hFFFF;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [6:0]  seg_drv = 7'h7F;
  logic [7:0]  an_drv = 8'hFF;
  logic        dp_drv = 1'b1;
  logic [31:0] digits;
  logic [7:0]  valid, bad;
  logic        an_err, frame;
  logic [7:0]  dp_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  seg_scan_capture #(.STABLE_CYCLES(S), .NUM_DIGITS(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .SEG_IN(seg_drv),
    .AN_IN (an_drv),
`ifdef SEG_CAPTURE_DP_EN
    .DP_IN (dp_drv),
    .DP_OUT(dp_out),
`endif
    .DIGITS(digits),
    .VALID (valid),
    .BAD   (bad),
    .AN_ERR(an_err),
    .FRAME (frame)
  );

`ifndef SEG_CAPTURE_DP_EN
  assign dp_out = 8'd0;
`endif

  // Reference model: a digit value is taken once a pin value has persisted S cycles
  logic [6:0]  seg_tab [16];
  logic [15:0] hist [$];
  int          run_len;
  bit          m_idle;
  logic [31:0] m_digits;
  logic [7:0]  m_valid, m_bad, m_seen, m_dp;
  logic        m_anerr, m_frame;
  logic [15:0] m_s, m_p;
  int          m_zeros, m_idx, m_nib;

  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
  end

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist = {BLANK_IN, BLANK_IN, BLANK_IN};
      run_len = 0; m_idle = 1;
      m_digits = 0; m_valid = 0; m_bad = 0; m_seen = 0; m_dp = 0;
      m_anerr = 0; m_frame = 0;
    end else begin
      m_frame = 0;
      hist.push_back({dp_drv, an_drv, seg_drv});
      m_s = hist[hist.size()-3];
      m_p = hist[hist.size()-4];
      if (hist.size() > 8) void'(hist.pop_front());
      run_len = (m_s == m_p) ? run_len + 1 : 1;
      if (m_idle && m_s != BLANK_IN) begin
        m_idle = 0;
        run_len = 1;
      end
      if (!m_idle && run_len == S) begin
        m_zeros = $countones(~m_s[14:7]);
        if (m_zeros > 1) m_anerr = 1;
        else if (m_zeros == 1) begin
          for (int i = 0; i < 8; i++) if (!m_s[7+i]) m_idx = i;
          m_nib = -1;
          for (int n = 0; n < 16; n++) if (seg_tab[n] == m_s[6:0]) m_nib = n;
          if (m_nib >= 0) begin
            m_digits[m_idx*4 +: 4] = m_nib[3:0];
            m_valid[m_idx] = 1; m_bad[m_idx] = 0;
          end else begin
            m_valid[m_idx] = 0;
            m_bad[m_idx] = (m_s[6:0] != 7'h7F);
          end
          m_dp[m_idx] = ~m_s[15];
          m_seen[m_idx] = 1;
          if (m_seen == 8'hFF) begin m_frame = 1; m_seen = 0; end
        end
      end
    end
  end

  task automatic drive(input logic [7:0] an, input logic [6:0] seg, input logic dp);
    an_drv = an; seg_drv = seg; dp_drv = dp;
  endtask

  task automatic test_reset;
    RST_N = 0;
    drive(8'hFF, 7'h7F, 1'b1);
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({digits, valid, bad, an_err, frame, dp_out} !== 58'd0) begin
      n_bad++;
      $display("FAIL reset_state: got digits=%h valid=%h bad=%h an_err=%b frame=%b dp=%h, expected all zero",
               digits, valid, bad, an_err, frame, dp_out);
    end
    RST_N = 1;
  endtask

  task automatic test_first_capture;
    drive(8'hFE, 7'h40, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (c == 5) begin
        n_cmp++;
        if (valid !== 8'h00) begin
          n_bad++; $display("FAIL first_early: valid=%h expected 00 before 2+S cycles", valid);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (digits[3:0] !== 4'h0 || valid !== 8'h01 || bad !== 8'h00 || frame !== 1'b0) begin
          n_bad++;
          $display("FAIL first_capture: digit0=%h valid=%h bad=%h frame=%b, expected 0 01 00 0",
                   digits[3:0], valid, bad, frame);
        end
      end
    end
  endtask

  task automatic test_scan;
    int frames = 0;
    for (int d = 0; d < 8; d++) begin
      drive(~(8'h01 << d), seg_tab[(d+1) % 16], 1'b1);
      for (int c = 0; c < 10; c++) begin
        if (c == 8) drive(8'hFF, 7'h7F, 1'b1);
        @(negedge CLK);
        if (frame === 1'b1) frames++;
        n_cmp++;
        if (frame !== m_frame) begin
          n_bad++; $display("FAIL scan_frame: frame=%b expected %b (digit %0d)", frame, m_frame, d);
        end
      end
    end
    n_cmp++;
    if (digits !== 32'h87654321 || valid !== 8'hFF || frames != 1) begin
      n_bad++;
      $display("FAIL scan_result: digits=%h valid=%h frames=%0d, expected 87654321 FF 1", digits, valid, frames);
    end
  endtask

  task automatic test_glitch;
    logic [31:0] saved;
    saved = digits;
    for (int t = 0; t < 4; t++) begin
      drive(8'hFB, (t % 2 == 0) ? 7'h40 : 7'h79, 1'b1);
      repeat (3) @(negedge CLK);
    end
    n_cmp++;
    if (digits !== saved) begin
      n_bad++; $display("FAIL glitch_hold: digits=%h expected unchanged %h", digits, saved);
    end
    repeat (8) @(negedge CLK);
    n_cmp++;
    if (digits[11:8] !== 4'h1 || valid[2] !== 1'b1) begin
      n_bad++; $display("FAIL glitch_settle: digit2=%h valid2=%b expected 1 1", digits[11:8], valid[2]);
    end
  endtask

  task automatic test_blank_bad;
    drive(8'hFD, 7'h7F, 1'b1);
    repeat (8) @(negedge CLK);
    n_cmp++;
    if (valid[1] !== 1'b0 || bad[1] !== 1'b0 || digits[7:4] !== 4'h2) begin
      n_bad++;
      $display("FAIL blank_digit: valid1=%b bad1=%b nib=%h expected 0 0 2", valid[1], bad[1], digits[7:4]);
    end
    drive(8'hFD, 7'h55, 1'b1);
    repeat (8) @(negedge CLK);
    n_cmp++;
    if (valid[1] !== 1'b0 || bad[1] !== 1'b1 || digits[7:4] !== 4'h2) begin
      n_bad++;
      $display("FAIL bad_digit: valid1=%b bad1=%b nib=%h expected 0 1 2", valid[1], bad[1], digits[7:4]);
    end
  endtask

  task automatic test_an_err;
    logic [31:0] saved;
    saved = digits;
    drive(8'hFC, 7'h40, 1'b1);
    repeat (8) @(negedge CLK);
    n_cmp++;
    if (an_err !== 1'b1 || digits !== saved) begin
      n_bad++; $display("FAIL an_err_set: an_err=%b digits=%h expected 1 %h", an_err, digits, saved);
    end
    drive(8'hFF, 7'h7F, 1'b1);
    repeat (8) @(negedge CLK);
    n_cmp++;
    if (an_err !== 1'b1) begin
      n_bad++; $display("FAIL an_err_sticky: an_err=%b expected 1", an_err);
    end
  endtask

  task automatic test_reset_mid_settle;
    int frames = 0;
    drive(8'hF7, 7'h19, 1'b1);
    repeat (4) @(negedge CLK);
    #2 RST_N = 0;
    #1;
    n_cmp++;
    if ({digits, valid, bad, an_err, frame, dp_out} !== 58'd0) begin
      n_bad++;
      $display("FAIL reset_async: digits=%h valid=%h bad=%h an_err=%b frame=%b, expected all zero",
               digits, valid, bad, an_err, frame);
    end
    drive(8'hFF, 7'h7F, 1'b1);
    repeat (2) @(negedge CLK);
    RST_N = 1;
    repeat (10) begin
      @(negedge CLK);
      if (frame === 1'b1) frames++;
    end
    n_cmp++;
    if (valid !== 8'h00 || digits !== 32'd0 || frames != 0) begin
      n_bad++;
      $display("FAIL reset_no_partial: valid=%h digits=%h frames=%0d expected 00 0 0", valid, digits, frames);
    end
  endtask

`ifdef SEG_CAPTURE_DP_EN
  task automatic test_dp;
    drive(8'hEF, 7'h08, 1'b0);
    repeat (8) @(negedge CLK);
    n_cmp++;
    if (digits[19:16] !== 4'hA || dp_out[4] !== 1'b1) begin
      n_bad++; $display("FAIL dp_capture: nib4=%h dp4=%b expected A 1", digits[19:16], dp_out[4]);
    end
    for (int t = 0; t < 5; t++) begin
      drive(8'hDF, 7'h12, t[0]);
      repeat (2) @(negedge CLK);
    end
    n_cmp++;
    if (valid[5] !== 1'b0) begin
      n_bad++; $display("FAIL dp_toggle: valid5=%b expected 0 while DP toggles", valid[5]);
    end
    repeat (8) @(negedge CLK);
    n_cmp++;
    if (valid[5] !== 1'b1 || digits[23:20] !== 4'h5 || dp_out[5] !== 1'b1) begin
      n_bad++;
      $display("FAIL dp_settle: valid5=%b nib5=%h dp5=%b expected 1 5 1", valid[5], digits[23:20], dp_out[5]);
    end
  endtask
`endif

  task automatic test_random;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    int         r;
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      an = ~(8'h01 << $urandom_range(0, 7));
      else if (r < 85) an = 8'hFF;
      else             an = 8'($urandom);
      r = $urandom_range(0, 99);
      if (r < 60)      seg = seg_tab[$urandom_range(0, 15)];
      else if (r < 75) seg = 7'h7F;
      else             seg = 7'($urandom);
`ifdef SEG_CAPTURE_DP_EN
      dp = 1'($urandom);
`else
      dp = 1'b1;
`endif
      drive(an, seg, dp);
      repeat ($urandom_range(1, 9)) begin
        @(negedge CLK);
        n_cmp++;
        if ({digits, valid, bad, an_err, frame} !== {m_digits, m_valid, m_bad, m_anerr, m_frame}
`ifdef SEG_CAPTURE_DP_EN
            || dp_out !== m_dp
`endif
           ) begin
          n_bad++;
          $display("FAIL random_model: it=%0d got %h/%h/%h/%b/%b dp=%h expected %h/%h/%h/%b/%b dp=%h",
                   it, digits, valid, bad, an_err, frame, dp_out,
                   m_digits, m_valid, m_bad, m_anerr, m_frame, m_dp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_capture();
    test_scan();
    test_glitch();
    test_blank_bad();
    test_an_err();
    test_reset_mid_settle();
`ifdef SEG_CAPTURE_DP_EN
    test_dp();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receiving end of the 7-segment display interface: samples a multiplexed, active-low segment/anode bus (Y/AN format, 8 digits) and recovers the hex value shown on each digit.
- Used as an on-board loopback/monitor so display drivers can be self-checked.
- Performs input synchronisation, settle filtering, pattern-to-nibble decoding, per-digit storage and frame detection.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before capture (legal range 1..255).
- NUM_DIGITS, 8, number of anodes/digits (fixed at 8 in this release; the parameter is for documentation only).

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST_N  input  1  asynchronous active-low reset
- SEG_IN  input  7  segment bus, active-low, bit0=a … bit6=g
- AN_IN  input  8  anode bus, active-low, one-hot-low when a digit is lit
- DIGITS  output  32  captured nibbles, digit i at [4i+3:4i]
- VALID  output  8  digit i holds a decoded value
- BAD  output  8  last capture on digit i was not a legal hex pattern
- AN_ERR  output  1  sticky: stable AN with more than one zero seen
- FRAME  output  1  one-cycle pulse when all 8 digits have been captured since the last pulse

Behaviour:
- Reset values: DIGITS=0, VALID=0, BAD=0, AN_ERR=0, FRAME=0, seen-mask=0, FSM=IDLE. Synchronisers reset to all-ones, i.e. blank.
- Inputs pass through a 2-FF synchroniser; the filter compares the synchronised {AN,SEG} against the previous sample.
- FSM IDLE: any sample differing from reset-blank → SETTLE with cnt=1.
- FSM SETTLE: a changed sample restarts at cnt=1. An equal sample increments cnt. When cnt==STABLE_CYCLES, capture this cycle and go to HOLD.
- FSM HOLD: no further captures. A changed sample → SETTLE with cnt=1.
- Capture rules:
  - AN all ones: no digit update (blanking interval).
  - AN exactly one zero at index i: decode SEG and mark seen[i].
  - AN with more than one zero: no update, AN_ERR<=1.
- Decode table (SEG hex → nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F.
  - Legal pattern: DIGITS[i]=nibble, VALID[i]=1, BAD[i]=0.
  - 7F (all segments off): VALID[i]=0, BAD[i]=0, nibble held.
  - Any other pattern: VALID[i]=0, BAD[i]=1, nibble held.
- Latency: pin change → DIGITS update = 2 + STABLE_CYCLES cycles. Outputs are registered.
- Frame: when the capture that completes seen==8'hFF occurs, FRAME=1 on the same edge as the DIGITS update and seen clears. The next frame then needs 8 fresh captures.
- Re-capturing an already-seen digit updates its value without affecting FRAME.
- Reset mid-SETTLE: all state is lost and no partial capture is produced.

Optional Feature:
- Macro SEG_CAPTURE_DP_EN.
- Defined: adds input DP_IN (1, active-low), included in the stability compare, and output DP_OUT (8), captured as ~DP_IN per digit alongside the nibble. DP_OUT resets to 0.
- Undefined: neither port exists, and DP has no effect on stability or capture.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16 active-low segment constants
  - SEG_BLANK=7'h7F
  - the FSM state enum {IDLE,SETTLE,HOLD}
  - a decode function returning {legal, nibble}
- The display driver side reuses the same constants.
- One sub-module, seg_sync_filter: 2-FF sync plus stability counter, emitting the stable sample and a one-cycle capture strobe.

Test Plan:
- Reset, then AN=FE, SEG=40 held 10 cycles → at cycle 2+4: DIGITS[3:0]=0, VALID=01, BAD=00, FRAME=0.
- Scan digits 0..7 with SEG 79,24,30,19,12,02,78,00 (each 8 cycles, blanked 2 cycles between) → DIGITS=32'h87654321, VALID=FF, single FRAME pulse.
- AN=FB, SEG toggles between 40 and 79 every 3 cycles → no capture, DIGITS unchanged. Then 79 held 4 cycles → DIGITS[11:8]=1.
- AN=FD, SEG=7F then SEG=55 → first capture VALID[1]=0, BAD[1]=0; second capture BAD[1]=1, nibble held.
- AN=FC stable → AN_ERR=1 sticky, no digit change. Assert RST_N low mid-SETTLE → all outputs 0 immediately.
- With SEG_CAPTURE_DP_EN: AN=EF, SEG=08, DP_IN=0 → DIGITS[19:16]=A, DP_OUT[4]=1. DP_IN toggling restarts settle.
